// File: rtl/leaf_router_if.sv
// leaf_router_if: flit buses between one group router and its four NIs plus the parent.
// The slave modport is the router's view; the master modport is the NI/parent side.
interface leaf_router_if #(
  parameter int DATA_W = 16
);
  logic [4*DATA_W-1:0] local_in_data;
  logic [3:0]          local_in_valid;
  logic [3:0]          local_in_ready;
  logic [4*DATA_W-1:0] local_out_data;
  logic [3:0]          local_out_valid;
  logic [DATA_W-1:0]   up_in_data;
  logic                up_in_valid;
  logic                up_in_ready;
  logic [DATA_W-1:0]   up_out_data;
  logic                up_out_valid;
  logic                up_out_ready;
  logic [7:0]          drop_cnt;

  modport master (
    output local_in_data, local_in_valid,
    input  local_in_ready,
    input  local_out_data, local_out_valid,
    output up_in_data, up_in_valid,
    input  up_in_ready,
    input  up_out_data, up_out_valid,
    output up_out_ready,
    input  drop_cnt
  );

  modport slave (
    input  local_in_data, local_in_valid,
    output local_in_ready,
    output local_out_data, local_out_valid,
    input  up_in_data, up_in_valid,
    output up_in_ready,
    output up_out_data, up_out_valid,
    input  up_out_ready,
    output drop_cnt
  );
endinterface

// File: rtl/leaf_router.sv
// leaf_router: five-input (4 leaves + uplink) header-routed crossbar for one GPU group.
// Each input has a small FIFO whose ready reserves a slot for the flit already in
// flight; each output has an independent round-robin arbiter. Leaf outputs are
// one-cycle strobes, the uplink output is a one-entry register slice with backpressure.
module leaf_router #(
  parameter logic [3:0] GROUP_ID = 4'd4,
  parameter int         DATA_W   = 16,
  parameter int         IN_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  leaf_router_if.slave bus
);
  localparam int             NIN      = 5;
  localparam int             AW       = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int             CW       = $clog2(IN_DEPTH + 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(IN_DEPTH);
  localparam logic [CW-1:0]  RDY_MAX  = CW'(IN_DEPTH - 2);
  localparam logic [2:0]     UP_IDX   = 3'd4;

  // Next index in the 0..4 ring, base + ofs modulo 5.
  function automatic logic [2:0] rr_next(input logic [2:0] base, input logic [2:0] ofs);
    logic [3:0] s;
    s = {1'b0, base} + {1'b0, ofs};
    if (s >= 4'd5) s = s - 4'd5;
    return s[2:0];
  endfunction

  // Saturating 8-bit increment for the drop counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [DATA_W-1:0] w_in_data [NIN];
  logic [NIN-1:0]    w_in_vld;
  logic [DATA_W-1:0] w_head [NIN];
  logic [NIN-1:0]    w_nempty;
  logic [NIN-1:0]    w_rdy;
  logic [NIN-1:0]    w_wr;
  logic [NIN-1:0]    w_pop;
  logic [NIN-1:0]    w_drop;
  logic [2:0]        w_dest [NIN];
  logic [NIN-1:0]    w_req [NIN];
  logic [NIN-1:0]    w_open;
  logic [NIN-1:0]    w_gnt;
  logic [2:0]        w_win [NIN];

  logic [2:0]        r_rrp [NIN];
  logic [3:0]        r_lout_vld_p1;
  logic [DATA_W-1:0] r_lout_data_p1 [4];
  logic              r_up_vld_p1;
  logic [DATA_W-1:0] r_up_data_p1;
  logic [7:0]        r_drop_cnt;

  // ---- stage p0: ingress FIFOs ----
  for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
    assign w_in_data[gi] = bus.local_in_data[gi*DATA_W +: DATA_W];
  end
  assign w_in_data[4] = bus.up_in_data;
  assign w_in_vld     = {bus.up_in_valid, bus.local_in_valid};

  for (genvar gi = 0; gi < NIN; gi++) begin : g_fifo
    logic [DATA_W-1:0] r_mem [IN_DEPTH];
    logic [AW-1:0]     r_rd;
    logic [AW-1:0]     r_wr;
    logic [CW-1:0]     r_cnt;

    // A strobe arriving while full is a sender protocol error and is dropped.
    assign w_wr[gi]     = w_in_vld[gi] && (r_cnt != FULL_CNT);
    assign w_nempty[gi] = (r_cnt != '0);
    assign w_rdy[gi]    = (r_cnt <= RDY_MAX);
    assign w_head[gi]   = r_mem[r_rd];

    // Flit storage; contents are meaningless while count is zero, so no reset.
    always_ff @(posedge clk) begin
      if (w_wr[gi]) r_mem[r_wr] <= w_in_data[gi];
    end

    // Read/write pointers and occupancy; write+pop in one cycle keeps the count.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_rd  <= '0;
        r_wr  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_wr[gi])  r_wr <= r_wr + 1'b1;
        if (w_pop[gi]) r_rd <= r_rd + 1'b1;
        case ({w_wr[gi], w_pop[gi]})
          2'b10:   r_cnt <= r_cnt + 1'b1;
          2'b01:   r_cnt <= r_cnt - 1'b1;
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  // Route decode on each FIFO head; misrouted uplink flits are marked for discard.
  always_comb begin
    for (int i = 0; i < NIN; i++) begin
      w_dest[i] = UP_IDX;
      w_drop[i] = 1'b0;
      if (w_head[i][DATA_W-1 -: 4] == GROUP_ID) begin
        w_dest[i] = {1'b0, w_head[i][DATA_W-5 -: 2]};
      end else if (i == NIN - 1) begin
        w_drop[i] = w_nempty[i];
      end
    end
  end

  // Request matrix: w_req[output][input].
  always_comb begin
    for (int o = 0; o < NIN; o++) begin
      w_req[o] = '0;
      for (int i = 0; i < NIN; i++) begin
        w_req[o][i] = w_nempty[i] && !w_drop[i] && (w_dest[i] == 3'(o));
      end
    end
  end

  // Leaf outputs always accept; the uplink slice accepts when empty or draining now.
  assign w_open = {!r_up_vld_p1 || bus.up_out_ready, 4'hF};

  // Round-robin pick per output: first requester at or after the pointer.
  always_comb begin
    for (int o = 0; o < NIN; o++) begin
      w_gnt[o] = 1'b0;
      w_win[o] = '0;
      for (int k = 0; k < NIN; k++) begin
        if (!w_gnt[o] && w_open[o] && w_req[o][rr_next(r_rrp[o], 3'(k))]) begin
          w_gnt[o] = 1'b1;
          w_win[o] = rr_next(r_rrp[o], 3'(k));
        end
      end
    end
  end

  // Pop every granted input plus a misrouted uplink head.
  always_comb begin
    w_pop = w_drop;
    for (int o = 0; o < NIN; o++) begin
      if (w_gnt[o]) w_pop[w_win[o]] = 1'b1;
    end
  end

  // Pointers advance past the winner only on a grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int o = 0; o < NIN; o++) r_rrp[o] <= '0;
    end else begin
      for (int o = 0; o < NIN; o++) begin
        if (w_gnt[o]) r_rrp[o] <= rr_next(w_win[o], 3'd1);
      end
    end
  end

  // ---- stage p1: output registers ----
  // Leaf delivery strobe: valid for exactly the cycle after a grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lout_vld_p1 <= '0;
      for (int o = 0; o < 4; o++) r_lout_data_p1[o] <= '0;
    end else begin
      for (int o = 0; o < 4; o++) begin
        r_lout_vld_p1[o] <= w_gnt[o];
        if (w_gnt[o]) r_lout_data_p1[o] <= w_head[w_win[o]];
      end
    end
  end

  // Uplink slice: load on grant, hold under backpressure, clear after handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_up_vld_p1  <= 1'b0;
      r_up_data_p1 <= '0;
    end else if (w_gnt[4]) begin
      r_up_vld_p1  <= 1'b1;
      r_up_data_p1 <= w_head[w_win[4]];
    end else if (bus.up_out_ready) begin
      r_up_vld_p1  <= 1'b0;
    end
  end

  // Count discarded misrouted uplink flits, saturating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop[4]) begin
      r_drop_cnt <= sat_inc8(r_drop_cnt);
    end
  end

  for (genvar go = 0; go < 4; go++) begin : g_pack
    assign bus.local_out_data[go*DATA_W +: DATA_W] = r_lout_data_p1[go];
  end
  assign bus.local_out_valid = r_lout_vld_p1;
  assign bus.local_in_ready  = w_rdy[3:0];
  assign bus.up_in_ready     = w_rdy[4];
  assign bus.up_out_data     = r_up_data_p1;
  assign bus.up_out_valid    = r_up_vld_p1;
  assign bus.drop_cnt        = r_drop_cnt;

endmodule

// File: tb/tb_leaf_router.sv
// tb_leaf_router: directed stimulus with a per-output scoreboard and a separate monitor.
module tb_leaf_router;
  localparam int         DATA_W   = 16;
  localparam int         IN_DEPTH = 4;
  localparam logic [3:0] GID      = 4'd4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  leaf_router_if #(.DATA_W(DATA_W)) bus();

  leaf_router #(.GROUP_ID(GID), .DATA_W(DATA_W), .IN_DEPTH(IN_DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t sbq [5][$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic mon_take(input int o, input logic [15:0] d);
    exp_t e;
    if (sbq[o].size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_out%0d: got %04h with nothing expected (cycle %0d)", o, d, cyc);
    end else begin
      e = sbq[o].pop_front();
      check($sformatf("out%0d_data", o), 32'(d), 32'(e.data));
      if (e.due >= 0) check($sformatf("out%0d_cycle", o), 32'(cyc), 32'(e.due));
    end
  endtask

  // Monitor: every delivery is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      for (int o = 0; o < 4; o++) begin
        if (bus.local_out_valid[o]) mon_take(o, bus.local_out_data[o*DATA_W +: DATA_W]);
      end
      if (bus.up_out_valid && bus.up_out_ready) mon_take(4, bus.up_out_data);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    bus.local_in_valid = '0;
    bus.up_in_valid    = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  // Drive one flit in the current cycle; dest is the hand-decoded output (-1: none).
  task automatic put(input int p, input logic [15:0] d, input int dest, input int due);
    exp_t e;
    if (p == 4) begin
      bus.up_in_data  = d;
      bus.up_in_valid = 1'b1;
    end else begin
      bus.local_in_data[p*DATA_W +: DATA_W] = d;
      bus.local_in_valid[p] = 1'b1;
    end
    if (dest >= 0) begin
      e.data = d;
      e.due  = due;
      sbq[dest].push_back(e);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_lout_valid"}, 32'(bus.local_out_valid), 32'h0);
    check({tag, "_lout_data"},  32'(bus.local_out_data),  32'h0);
    check({tag, "_up_valid"},   32'(bus.up_out_valid),    32'h0);
    check({tag, "_up_data"},    32'(bus.up_out_data),     32'h0);
    check({tag, "_in_ready"},   32'(bus.local_in_ready),  32'hF);
    check({tag, "_up_in_ready"},32'(bus.up_in_ready),     32'h1);
    check({tag, "_drop_cnt"},   32'(bus.drop_cnt),        32'h0);
  endtask

  initial begin
    int ok;
    int sent;
    int sent_at_fall;

    bus.local_in_data  = '0;
    bus.local_in_valid = '0;
    bus.up_in_data     = '0;
    bus.up_in_valid    = 1'b0;
    bus.up_out_ready   = 1'b1;

    // Reset state
    #1;
    check_idle_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Round robin: all five inputs target leaf 3 in one cycle
    next_cycle();
    for (int p = 0; p < 5; p++) put(p, 16'h4C00 | 16'(p), 3, cyc + 2 + p);
    wait_cycles(8);

    // Single flit leaf0 -> leaf2, due two cycles later
    next_cycle();
    put(0, 16'h4815, 2, cyc + 2);
    wait_cycles(5);

    // Mixed routes in one cycle: loopback, uplink->leaf, leaf->leaf, leaf->uplink
    next_cycle();
    put(2, 16'h4BCD, 2, cyc + 2);
    put(4, 16'h4C55, 3, cyc + 2);
    put(3, 16'h4401, 1, cyc + 2);
    put(1, 16'h8000, 4, cyc + 2);
    wait_cycles(5);

    // Uplink egress under backpressure
    bus.up_out_ready = 1'b0;
    next_cycle();
    put(1, 16'h1234, 4, -1);
    next_cycle();
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.up_out_valid), 32'h1);
      check("hold_data",  32'(bus.up_out_data),  32'h1234);
      next_cycle();
    end
    bus.up_out_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    check("valid_drop_after_hs", 32'(bus.up_out_valid), 32'h0);

    // Backpressure: leaf 0 streams to uplink while the parent stalls
    bus.up_out_ready = 1'b0;
    next_cycle();
    ok = int'(bus.local_in_ready[0]);
    sent = 0;
    sent_at_fall = -1;
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      if (ok != 0 && sent < 8) begin
        put(0, 16'h2000 | 16'(sent), 4, -1);
        sent++;
      end
      ok = int'(bus.local_in_ready[0]);
      if (ok == 0 && sent_at_fall < 0) sent_at_fall = sent;
    end
    check("bp_sent_when_ready_fell", 32'(sent_at_fall), 32'(IN_DEPTH + 1));
    check("bp_absorbed",             32'(sent),         32'(IN_DEPTH + 1));
    check("bp_ready_low",            32'(bus.local_in_ready[0]), 32'h0);
    next_cycle();
    bus.up_out_ready = 1'b1;
    wait_cycles(10);
    check("bp_all_drained", 32'(sbq[4].size()), 32'h0);

    // Misroute from the parent: dropped and counted
    next_cycle();
    put(4, 16'h0400, -1, -1);
    wait_cycles(4);
    check("drop_cnt_one", 32'(bus.drop_cnt), 32'd1);
    ok = int'(bus.up_in_ready);
    sent = 1;
    for (int i = 0; i < 1000 && sent < 300; i++) begin
      next_cycle();
      if (ok != 0) begin
        put(4, 16'h0400, -1, -1);
        sent++;
      end
      ok = int'(bus.up_in_ready);
    end
    check("drop_sent", 32'(sent), 32'd300);
    wait_cycles(4);
    check("drop_cnt_sat", 32'(bus.drop_cnt), 32'd255);

    // Async reset with flits buffered toward a stalled uplink
    bus.up_out_ready = 1'b0;
    next_cycle();
    put(0, 16'h2100, -1, -1);
    put(1, 16'h2200, -1, -1);
    put(2, 16'h2300, -1, -1);
    wait_cycles(3);
    check("pre_reset_buffered", 32'(bus.up_out_valid), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();
    bus.up_out_ready = 1'b1;
    wait_cycles(8);
    check("no_stale_up", 32'(bus.up_out_valid), 32'h0);

    for (int o = 0; o < 5; o++) check($sformatf("leftover_q%0d", o), 32'(sbq[o].size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
